// File: rtl/rx_lane_scheduler_pkg.sv
// Shared definitions for the phy_rx byte path: FSM encoding and K-symbol values.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam logic [7:0] IDL_SYM = 8'h7C;

endpackage

// File: rtl/rx_lane_scheduler_if.sv
// Serial byte input and lane-strobe output bundle of the rx lane scheduler.
interface rx_lane_scheduler_if;

    logic [7:0] data_000;
    logic       valid_000;
    logic [3:0] lane_we;
    logic [7:0] lane_data;
    logic       frame_done;
    logic       locked;
    logic [1:0] state;

    modport master (
        output data_000, valid_000,
        input  lane_we, lane_data, frame_done, locked, state
    );

    modport slave (
        input  data_000, valid_000,
        output lane_we, lane_data, frame_done, locked, state
    );

endinterface

// File: rtl/rx_lane_scheduler_sat_counter4.sv
// 4-bit counter that saturates at 15; clear and increment together load 1.
module sat_counter4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic [3:0] nxt
);

    always_comb begin
        nxt = clr ? 4'd0 : q;
        if (inc && nxt != 4'hF)
            nxt = nxt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= 4'd0;
        else
            q <= nxt;
    end

endmodule

// File: rtl/rx_lane_scheduler.sv
// COM-marker alignment FSM and one-hot lane strobe generator for the 4-lane rx demux.
module rx_lane_scheduler
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM        = COM_SYM,
    parameter logic [3:0] LOCK_COUNT = 4'd4,
    parameter logic [3:0] LOSS_COUNT = 4'd4
) (
    input  logic                 clk_4f,
    input  logic                 reset_L,
    rx_lane_scheduler_if.slave   bus
);

    state_t     state_q, state_n;
    logic [1:0] ptr_q, ptr_n;
    logic [3:0] we_q, we_n;
    logic [7:0] data_q, data_n;
    logic       done_q;

    logic       is_com;
    logic       com_clr, com_inc, err_clr, err_inc;
    logic [3:0] com_cnt, com_nxt, err_cnt, err_nxt;

    assign is_com = (bus.data_000 == COM);

    sat_counter4 u_com_cnt (
        .clk (clk_4f), .rst_n (reset_L),
        .clr (com_clr), .inc (com_inc),
        .q   (com_cnt), .nxt (com_nxt)
    );

    sat_counter4 u_err_cnt (
        .clk (clk_4f), .rst_n (reset_L),
        .clr (err_clr), .inc (err_inc),
        .q   (err_cnt), .nxt (err_nxt)
    );

    // Each counter is only meaningful in one mode, so the other is held at
    // zero; this gives the clean start on lock/loss without a feedback path.
    always_comb begin
        com_clr = 1'b0;
        com_inc = 1'b0;
        err_clr = 1'b0;
        err_inc = 1'b0;
        if (state_q == ST_LOCKED) begin
            com_clr = 1'b1;
            if (bus.valid_000) begin
                if ((ptr_q == 2'd0) != is_com)
                    err_inc = 1'b1;
                else if (is_com)
                    err_clr = 1'b1;
            end
        end else begin
            err_clr = 1'b1;
            if (bus.valid_000) begin
                if (is_com) begin
                    com_inc = 1'b1;
                    com_clr = (ptr_q != 2'd0);
                end else if (ptr_q == 2'd0) begin
                    com_clr = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        we_n    = 4'd0;
        data_n  = data_q;
        if (bus.valid_000) begin
            unique case (state_q)
                ST_IDLE, ST_SEARCH: begin
                    ptr_n   = is_com ? 2'd1 : ptr_q + 2'd1;
                    state_n = (com_nxt == LOCK_COUNT) ? ST_LOCKED : ST_SEARCH;
                end
                ST_LOCKED: begin
                    we_n   = 4'b0001 << ptr_q;
                    data_n = bus.data_000;
                    ptr_n  = ptr_q + 2'd1;
                    if (err_nxt == LOSS_COUNT) begin
                        state_n = ST_SEARCH;
                        ptr_n   = 2'd0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            we_q    <= 4'd0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            we_q    <= we_n;
            data_q  <= data_n;
            done_q  <= we_n[3];
        end
    end

    assign bus.lane_we    = we_q;
    assign bus.lane_data  = data_q;
    assign bus.frame_done = done_q;
    assign bus.locked     = (state_q == ST_LOCKED);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_rx_lane_scheduler.sv
// Directed scoreboard bench for rx_lane_scheduler: lock, gaps, loss, realign and reset.
module tb_rx_lane_scheduler;
    import phy_rx_pkg::*;

    logic clk_4f  = 1'b0;
    logic reset_L = 1'b0;

    always #5 clk_4f = ~clk_4f;

    rx_lane_scheduler_if bus ();

    rx_lane_scheduler dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    typedef struct packed {
        logic [3:0] we;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented lane write is matched against the scoreboard.
    always @(negedge clk_4f) begin
        wr_t e;
        if (reset_L) begin
            if (bus.lane_we != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(bus.lane_we), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("lane_we", 32'(bus.lane_we), 32'(e.we));
                    chk("lane_data", 32'(bus.lane_data), 32'(e.d));
                    chk("frame_done", 32'(bus.frame_done), 32'(e.we[3]));
                end
            end else if (bus.frame_done) begin
                chk("frame_done_idle", 32'(bus.frame_done), 32'd0);
            end
        end
    end

    task automatic step(input logic [7:0] b, input logic v);
        bus.data_000  = b;
        bus.valid_000 = v;
        @(negedge clk_4f);
        #1;
    endtask

    task automatic stepw(input logic [7:0] b, input int lane);
        wr_t e;
        e.we = 4'b0001 << lane;
        e.d  = b;
        exp_q.push_back(e);
        step(b, 1'b1);
        chk("write_missing", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"},     32'(bus.lane_we),    32'd0);
        chk({tag, "_data"},   32'(bus.lane_data),  32'd0);
        chk({tag, "_done"},   32'(bus.frame_done), 32'd0);
        chk({tag, "_locked"}, 32'(bus.locked),     32'd0);
        chk({tag, "_state"},  32'(bus.state),      32'd0);
    endtask

    task automatic body(); // 01,02,03 while searching
        step(8'h01, 1'b1);
        step(8'h02, 1'b1);
        step(8'h03, 1'b1);
    endtask

    task automatic body_w(); // 01,02,03 written to lanes 1..3
        stepw(8'h01, 1);
        stepw(8'h02, 2);
        stepw(8'h03, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_000  = 8'h00;
        bus.valid_000 = 1'b0;

        // Reset held with random input
        repeat (4) begin
            bus.data_000  = 8'($urandom);
            bus.valid_000 = 1'($urandom);
            @(negedge clk_4f);
            #1;
            chk_zero("reset");
        end
        reset_L = 1'b1;
        step(8'h11, 1'b1);
        chk("idle_to_search", 32'(bus.state), 32'd1);
        body(); // ptr back to 0

        // Clean lock
        for (int k = 1; k <= 4; k++) begin
            step(COM_SYM, 1'b1);
            chk("clean_locked", 32'(bus.locked), (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) body();
        end
        chk("clean_state", 32'(bus.state), 32'd2);
        body_w();
        stepw(COM_SYM, 0);

        // Valid gap mid-frame
        stepw(8'h01, 1);
        repeat (3) begin
            step(COM_SYM, 1'b0);
            chk("gap_we", 32'(bus.lane_we), 32'd0);
        end
        stepw(8'h02, 2);
        stepw(8'h03, 3);
        stepw(COM_SYM, 0);
        chk("gap_locked", 32'(bus.locked), 32'd1);

        // Single missing COM, then a good one
        body_w();
        stepw(8'h00, 0);
        body_w();
        stepw(COM_SYM, 0);
        chk("single_miss_locked", 32'(bus.locked), 32'd1);

        // Four consecutive missing COMs
        for (int k = 1; k <= 4; k++) begin
            body_w();
            stepw(8'h00, 0);
            chk("loss_locked", 32'(bus.locked), (k == 4) ? 32'd0 : 32'd1);
        end
        chk("loss_state", 32'(bus.state), 32'd1);

        // Misaligned start: realign at first BC
        step(8'h55, 1'b1);
        step(8'h66, 1'b1);
        step(COM_SYM, 1'b1);
        body();
        for (int k = 2; k <= 4; k++) begin
            step(COM_SYM, 1'b1);
            chk("realign_locked", 32'(bus.locked), (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) body();
        end
        stepw(8'h01, 1);
        stepw(8'h02, 2);
        chk("pre_reset_we", 32'(bus.lane_we), 32'b0100);

        // Asynchronous reset mid-frame
        reset_L = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk_4f);
        #1;
        reset_L = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(COM_SYM, 1'b1);
            chk("relock_locked", 32'(bus.locked), (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) body();
        end
        stepw(8'h01, 1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_lane_scheduler.md
# rx_lane_scheduler

Alignment and sequencing controller for the phy_rx byte demultiplexer, running in the `clk_4f` domain. It watches the serial byte stream `data_000`/`valid_000` and locks onto the COM marker (0xBC) recurring every fourth valid byte. Once locked, it issues one-hot lane write strobes with a registered data copy, so the downstream four-lane demux lands each COM in lane 0. Lane writes are suppressed while searching, and lock drops after repeated marker errors.

## Interface
- `COM`, 8'hBC, alignment marker byte expected in lane-0 position.
- `LOCK_COUNT`, 4, consecutive correctly spaced COMs required to lock (range 1–15).
- `LOSS_COUNT`, 4, consecutive missing or misplaced COMs, while locked, that force a return to search (range 1–15).

- `clk_4f`  in  1  byte clock; all logic on rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `data_000`  in  8  incoming serial byte.
- `valid_000`  in  1  `data_000` qualifier.
- `lane_we`  out  4  one-hot lane write strobe, registered; 0 when no write.
- `lane_data`  out  8  registered copy of the written byte.
- `frame_done`  out  1  one-cycle pulse coincident with `lane_we[3]`.
- `locked`  out  1  high in LOCKED state.
- `state`  out  2  FSM state: IDLE=0, SEARCH=1, LOCKED=2.

## Operation
- Internal registers:
  - `ptr[1:0]`: lane pointer.
  - `com_cnt[3:0]`: good-COM count.
  - `err_cnt[3:0]`: error count.
- All outputs, `ptr` and the counters reset to 0; `state` resets to IDLE.
- A cycle with `valid_000`=0 changes nothing: `ptr`, counters and state hold, and `lane_we`=0 next cycle.
- **IDLE:** on the first valid byte, go to SEARCH and process that byte with SEARCH rules in the same cycle.
- **SEARCH:** no lane writes; `lane_we` stays 0. For each valid byte:
  - byte==COM and `ptr`==0: `com_cnt`++; `ptr`←1.
  - byte==COM and `ptr`≠0: realign. `com_cnt`←1; `ptr`←1.
  - byte≠COM and `ptr`==0: `com_cnt`←0; `ptr`←1.
  - otherwise: `ptr`++ (wraps 3→0).
  - If the updated `com_cnt` equals `LOCK_COUNT`, go to LOCKED with `err_cnt`←0. The locking COM itself is not written.
- **LOCKED:** every valid byte is written.
  - `lane_we[ptr]`←1, `lane_data`←byte, then `ptr`++ with wrap.
  - Error condition: (`ptr`==0 and byte≠COM) or (`ptr`≠0 and byte==COM). On error, `err_cnt`++.
  - COM at `ptr`==0 clears `err_cnt`.
  - If the updated `err_cnt` equals `LOSS_COUNT`, go to SEARCH with `com_cnt`←0 and `ptr`←0. The offending byte is still written.
- `frame_done` is asserted whenever `lane_we[3]` is asserted.
- Counters saturate at 15 and never wrap.

## Timing
- Latency: byte sampled at edge N appears on `lane_we`/`lane_data` after edge N; one-cycle latency.
- `locked` and `state` are registered. They rise on the edge that samples the `LOCK_COUNT`-th COM; the next valid byte is the first one written, to lane 1.
- Back-to-back valid bytes give one write per cycle; gaps insert idle cycles with no lane skip.
- Loss: `locked` falls on the edge that samples the `LOSS_COUNT`-th error. That byte's write still appears in the same cycle.
- Asynchronous `reset_L` assertion mid-frame immediately zeroes all outputs and drops lock. After deassertion, the FSM restarts from IDLE with no partial frame carried.

## Structure
- Shared package `phy_rx_pkg`:
  - state encoding constants `ST_IDLE`, `ST_SEARCH`, `ST_LOCKED`;
  - `COM_SYM`=8'hBC;
  - `IDL_SYM`=8'h7C, reserved for the transmit side.
- One natural sub-module, `sat_counter4`: 4-bit saturating counter with clear/increment. It is instantiated twice, for `com_cnt` and `err_cnt`.
- The FSM and pointer stay in the top module.

## Test plan
- **Reset:** hold `reset_L`=0 with random input → all outputs 0, `state`=0. Release, then feed a valid byte → `state`=1.
- **Clean lock:** stream BC,01,02,03 repeated, `valid_000`=1 continuous → `locked`=1 on the 4th BC. The next bytes produce `lane_we` 0010,0100,1000 (with `frame_done`), then 0001 carrying `lane_data`=BC.
- **Misaligned start:** stream 55,66,BC,01,02,03,BC,… → realign at the first BC; lock after the 4th correctly spaced BC; no `lane_we` before lock.
- **Valid gaps:** locked stream with `valid_000` deasserted for 3 cycles mid-frame → `lane_we`=0 during the gap; resumes at the next lane; no error counted.
- **Loss:** while locked, replace BC with 00 in 4 consecutive frames → `err_cnt` reaches 4; `locked` falls with the 4th 00, which is still written to lane 0. A single missing BC followed by a good BC → stays locked, `err_cnt`=0.
- **Reset mid-frame:** assert `reset_L` after `lane_we`=0100 → outputs 0 immediately; relock requires 4 fresh COMs.
